// File: rtl/shift4_ctrl.sv
// shift4_ctrl: round-robin two-way arbiter and sequencer for a serial shift register.
// Optional freeze input enabled by defining SHIFT4_CTRL_PAUSE_EN.
module shift4_ctrl #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            areset,
`ifdef SHIFT4_CTRL_PAUSE_EN
    input  logic            pause_i,
`endif
    input  logic [1:0]      req_valid_i,
    input  logic [SIZE-1:0] req_data0_i,
    input  logic [SIZE-1:0] req_data1_i,
    output logic [1:0]      req_ready_o,
    output logic            sr_load_o,
    output logic            sr_ena_o,
    output logic [SIZE-1:0] sr_data_o,
    input  logic [SIZE-1:0] sr_q_i,
    output logic            ser_valid_o,
    output logic            ser_bit_o,
    output logic            grant_id_o,
    output logic            frame_done_o,
    output logic            busy_o
);

    localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gid_q, gid_d;

    logic pause;
    logic have_win;
    logic win;
    logic last_bit;
    logic slot;

`ifdef SHIFT4_CTRL_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif

    assign have_win   = |req_valid_i;
    assign last_bit   = (cnt_q == LAST);
    assign ser_bit_o  = sr_q_i[0];
    assign busy_o     = (state_q == SHIFT);
    assign grant_id_o = gid_q;

    // Pick the winner: a lone requester, or the one not served last.
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (req_valid_i == 2'b01): win = 1'b0;
            (req_valid_i == 2'b10): win = 1'b1;
            (req_valid_i == 2'b11): win = ~last_q;
            (req_valid_i == 2'b00): win = 1'b0;
        endcase
    end

    // Next state and all shift-register controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        gid_d        = gid_q;
        req_ready_o  = 2'b00;
        sr_load_o    = 1'b0;
        sr_ena_o     = 1'b0;
        sr_data_o    = '0;
        ser_valid_o  = 1'b0;
        frame_done_o = 1'b0;
        slot         = 1'b0;
        if (!areset) begin
            unique case (state_q)
                IDLE: begin
                    slot = 1'b1;
                end
                SHIFT: begin
                    if (!pause) begin
                        ser_valid_o = 1'b1;
                        sr_ena_o    = 1'b1;
                        if (last_bit) begin
                            frame_done_o = 1'b1;
                            slot         = 1'b1;
                            state_d      = IDLE;
                            cnt_d        = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (slot && have_win) begin
                req_ready_o = win ? 2'b10 : 2'b01;
                sr_load_o   = 1'b1;
                sr_data_o   = win ? req_data1_i : req_data0_i;
                last_d      = win;
                gid_d       = win;
                cnt_d       = '0;
                state_d     = SHIFT;
            end
        end
    end

    // State registers; requester 0 wins the first contention.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
        end
    end

    // The register is drained on every frame end, so it is empty in IDLE.
    a_idle_empty: assert property (
        @(posedge clk) disable iff (areset)
        (state_q == IDLE) |-> (sr_q_i == '0)
    );

    // At most one requester is accepted per cycle.
    a_ready_onehot: assert property (
        @(posedge clk) disable iff (areset)
        $onehot0(req_ready_o)
    );

endmodule

// File: tb/tb_shift4_ctrl.sv
// tb_shift4_ctrl: directed vector table plus multi-cycle sequences.
// Includes a behavioural shift register closing the loop on sr_q.
module tb_shift4_ctrl;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req_data0 = 4'h0;
    logic [3:0] req_data1 = 4'h0;
    logic [1:0] req_ready;
    logic       sr_load, sr_ena;
    logic [3:0] sr_data;
    logic [3:0] sr_q;
    logic       ser_valid, ser_bit, grant_id, frame_done, busy;
`ifdef SHIFT4_CTRL_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    shift4_ctrl #(.SIZE(4)) dut (
        .clk         (clk),
        .areset      (areset),
`ifdef SHIFT4_CTRL_PAUSE_EN
        .pause_i     (pause),
`endif
        .req_valid_i (req_valid),
        .req_data0_i (req_data0),
        .req_data1_i (req_data1),
        .req_ready_o (req_ready),
        .sr_load_o   (sr_load),
        .sr_ena_o    (sr_ena),
        .sr_data_o   (sr_data),
        .sr_q_i      (sr_q),
        .ser_valid_o (ser_valid),
        .ser_bit_o   (ser_bit),
        .grant_id_o  (grant_id),
        .frame_done_o(frame_done),
        .busy_o      (busy)
    );

    // Shift register: load beats ena, zero fill on right shift.
    always_ff @(posedge clk or posedge areset) begin
        if (areset)       sr_q <= 4'h0;
        else if (sr_load) sr_q <= sr_data;
        else if (sr_ena)  sr_q <= {1'b0, sr_q[3:1]};
    end

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] v,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic [1:0] rdy, input logic ld,
                       input logic en, input logic sv, input logic b,
                       input logic fd, input logic bs, input logic g,
                       input logic [3:0] q);
        vec_t r;
        r.rst = rst;
        r.v   = v;
        r.d0  = d0;
        r.d1  = d1;
        r.exp = {rdy, ld, en, sv, b, fd, bs, g, q};
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [12:0] act,
                         input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {req_ready, sr_load, sr_ena, ser_valid, ser_bit,
                frame_done, busy, grant_id, sr_q};
    endfunction

    initial begin
        logic [3:0] word;
        int n;
        int nb;
        int nfd;
        logic done;

        // Single request, word 1011: bits 1,1,0,1 then idle and empty.
        add(1, 2'b00, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b01, 4'hB, 4'h5, 2'b01, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'hB);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'h2);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 1, 1, 0, 4'h1);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        // Contention A/5 from reset: grants 0,1,0,1 with no gap.
        add(1, 2'b00, 4'hA, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b11, 4'hA, 4'h5, 2'b01, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'hA);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'h2);
        add(0, 2'b11, 4'hA, 4'h5, 2'b10, 1, 1, 1, 1, 1, 1, 0, 4'h1);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h5);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 1, 4'h2);
        add(0, 2'b11, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h1);
        add(0, 2'b11, 4'hA, 4'h5, 2'b01, 1, 1, 1, 0, 1, 1, 1, 4'h0);
        add(0, 2'b10, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'hA);
        add(0, 2'b10, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(0, 2'b10, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'h2);
        add(0, 2'b10, 4'hA, 4'h5, 2'b10, 1, 1, 1, 1, 1, 1, 0, 4'h1);
        add(0, 2'b00, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h5);
        add(0, 2'b00, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 1, 4'h2);
        add(0, 2'b00, 4'hA, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h1);
        add(0, 2'b00, 4'hA, 4'h5, 2'b00, 0, 1, 1, 0, 1, 1, 1, 4'h0);
        add(0, 2'b00, 4'hA, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'h0);
        // Late arrival of requester 1 in the 2nd frame cycle.
        add(0, 2'b01, 4'hB, 4'h5, 2'b01, 1, 0, 0, 0, 0, 0, 1, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'hB);
        add(0, 2'b10, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(0, 2'b10, 4'hB, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'h2);
        add(0, 2'b10, 4'hB, 4'h5, 2'b10, 1, 1, 1, 1, 1, 1, 0, 4'h1);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h5);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 1, 4'h2);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 1, 4'h1);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 0, 1, 1, 1, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 1, 4'h0);
        // Reset after two bits, then requester 0 wins contention.
        add(0, 2'b01, 4'hB, 4'h5, 2'b01, 1, 0, 0, 0, 0, 0, 1, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'hB);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(1, 2'b01, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b11, 4'hB, 4'h5, 2'b01, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'hB);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 0, 1, 0, 4'h5);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 0, 0, 1, 0, 4'h2);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 1, 1, 1, 1, 1, 0, 4'h1);
        add(0, 2'b00, 4'hB, 4'h5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            areset    = vecs[i].rst;
            req_valid = vecs[i].v;
            req_data0 = vecs[i].d0;
            req_data1 = vecs[i].d1;
            #2;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Requester 1 alone, word 0110: bounded wait, rebuild the word.
        @(negedge clk);
        req_valid = 2'b10;
        req_data1 = 4'h6;
        #2;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 8) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("hs_wait", {12'h0, req_ready[1]}, 13'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #2;
        word = 4'h0;
        nb   = 0;
        nfd  = 0;
        done = 1'b0;
        n    = 0;
        while (!done && n < 8) begin
            if (ser_valid === 1'b1 && nb < 4) begin
                word[nb] = ser_bit;
                nb++;
            end
            if (frame_done === 1'b1) begin
                nfd++;
                done = 1'b1;
            end else begin
                @(negedge clk);
                #2;
                n++;
            end
        end
        check("frame_word", {4'h0, nfd[0], nb[3:0], word},
              {4'h0, 1'b1, 4'd4, 4'h6});

`ifdef SHIFT4_CTRL_PAUSE_EN
        // Pause three cycles after bit 1: bits 2..4 slide, one done pulse.
        begin
            logic [2:0] pexp [9];
            logic       pin  [9];
            logic [1:0] pv   [9];
            pexp = '{3'b000, 3'b110, 3'b000, 3'b000, 3'b000,
                     3'b110, 3'b100, 3'b111, 3'b000};
            pin  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
            pv   = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00,
                     2'b00, 2'b00, 2'b00, 2'b00};
            @(negedge clk);
            #2;
            nfd = 0;
            req_data0 = 4'hB;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                req_valid = pv[k];
                pause     = pin[k];
                #2;
                if (frame_done === 1'b1) nfd++;
                check($sformatf("pause%0d", k),
                      {10'h0, ser_valid, ser_bit, frame_done},
                      {10'h0, pexp[k]});
            end
            check("pause_fd", {12'h0, nfd == 1}, 13'h1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
